// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - wash/rinse/spin programme sequencer driven by a 1 Hz tick
module wash_sequencer #(
    parameter int WASH_T  = 9,
    parameter int RINSE_T = 6,
    parameter int SPIN_T  = 3,
    parameter int BEEP_T  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       power_led,
    input  logic       start_pause,
    input  logic [2:0] model_now,
    output logic       if_finish,
    output logic [2:0] phase_led,
    output logic       wash_motor,
    output logic       water_in,
    output logic       drain,
    output logic       spin_motor,
    output logic       buzzer,
    output logic [7:0] remain_time
);

    typedef enum logic [2:0] {IDLE, WASH, RINSE, SPIN, DONE} state_t;

    localparam logic [5:0] WASH_D  = 6'(WASH_T);
    localparam logic [5:0] RINSE_D = 6'(RINSE_T);
    localparam logic [5:0] SPIN_D  = 6'(SPIN_T);
    localparam logic [3:0] BEEP_D  = 4'(BEEP_T);

    state_t     state, state_next, first_state, following_state;
    logic [2:0] mode_q, mode_next;
    logic       sp_q;
    logic [5:0] phase_cnt, phase_cnt_next;
    logic [7:0] remain_cnt, remain_next, start_sum;
    logic [3:0] beep_cnt, beep_next;
    logic       done_pulse, done_next;
    logic [2:0] start_mask, run_mask;
    logic [5:0] cur_dur;

    // Bit order {spin, rinse, wash}; unused codes fall back to the full programme.
    function automatic logic [2:0] phase_mask(input logic [2:0] m);
        case (m)
            3'd1:    phase_mask = 3'b001;
            3'd2:    phase_mask = 3'b011;
            3'd3:    phase_mask = 3'b110;
            3'd4:    phase_mask = 3'b010;
            3'd5:    phase_mask = 3'b100;
            default: phase_mask = 3'b111;
        endcase
    endfunction

    function automatic logic [5:0] phase_dur(input state_t s);
        case (s)
            WASH:    phase_dur = WASH_D;
            RINSE:   phase_dur = RINSE_D;
            SPIN:    phase_dur = SPIN_D;
            default: phase_dur = 6'd0;
        endcase
    endfunction

    always_comb begin
        start_mask = phase_mask(model_now);
        run_mask   = phase_mask(mode_q);
        cur_dur    = phase_dur(state);
        if (start_mask[0])      first_state = WASH;
        else if (start_mask[1]) first_state = RINSE;
        else                    first_state = SPIN;
        start_sum = (start_mask[0] ? 8'(WASH_D)  : 8'd0)
                  + (start_mask[1] ? 8'(RINSE_D) : 8'd0)
                  + (start_mask[2] ? 8'(SPIN_D)  : 8'd0);
        case (state)
            WASH:    following_state = run_mask[1] ? RINSE : (run_mask[2] ? SPIN : DONE);
            RINSE:   following_state = run_mask[2] ? SPIN : DONE;
            default: following_state = DONE;
        endcase
    end

    always_comb begin
        state_next     = state;
        mode_next      = mode_q;
        phase_cnt_next = phase_cnt;
        remain_next    = remain_cnt;
        beep_next      = beep_cnt;
        done_next      = 1'b0;
        if (!power_led) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_pause && !sp_q) begin
                        mode_next      = model_now;
                        state_next     = first_state;
                        phase_cnt_next = phase_dur(first_state);
                        remain_next    = start_sum;
                    end
                end
                WASH, RINSE, SPIN: begin
                    if (start_pause && sec_tick) begin
                        remain_next    = (remain_cnt != 8'd0) ? remain_cnt - 8'd1 : 8'd0;
                        phase_cnt_next = phase_cnt - 6'd1;
                        if (phase_cnt <= 6'd1) begin
                            state_next = following_state;
                            if (following_state == DONE) begin
                                beep_next   = BEEP_D;
                                done_next   = 1'b1;
                                remain_next = 8'd0;
                            end else begin
                                phase_cnt_next = phase_dur(following_state);
                            end
                        end
                    end
                end
                DONE: begin
                    if (sec_tick) begin
                        beep_next = (beep_cnt != 4'd0) ? beep_cnt - 4'd1 : 4'd0;
                        if (beep_cnt <= 4'd1) state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mode_q     <= 3'd0;
            sp_q       <= 1'b0;
            phase_cnt  <= 6'd0;
            remain_cnt <= 8'd0;
            beep_cnt   <= 4'd0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            mode_q     <= mode_next;
            sp_q       <= start_pause;
            phase_cnt  <= phase_cnt_next;
            remain_cnt <= remain_next;
            beep_cnt   <= beep_next;
            done_pulse <= done_next;
        end
    end

    // Output stage lags the state by one clk; power_led gates it so power loss clears at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_finish   <= 1'b0;
            phase_led   <= 3'b000;
            wash_motor  <= 1'b0;
            water_in    <= 1'b0;
            drain       <= 1'b0;
            spin_motor  <= 1'b0;
            buzzer      <= 1'b0;
            remain_time <= 8'd0;
        end else begin
            if_finish   <= 1'b0;
            phase_led   <= 3'b000;
            wash_motor  <= 1'b0;
            water_in    <= 1'b0;
            drain       <= 1'b0;
            spin_motor  <= 1'b0;
            buzzer      <= 1'b0;
            remain_time <= 8'd0;
            if (power_led) begin
                if_finish <= done_pulse;
                case (state)
                    WASH: begin
                        phase_led   <= 3'b001;
                        remain_time <= remain_cnt;
                        wash_motor  <= start_pause;
                        water_in    <= start_pause && ({1'b0, phase_cnt} + 7'd2 > {1'b0, cur_dur});
                    end
                    RINSE: begin
                        phase_led   <= 3'b010;
                        remain_time <= remain_cnt;
                        wash_motor  <= start_pause;
                        water_in    <= start_pause && ({1'b0, phase_cnt} + 7'd2 > {1'b0, cur_dur});
                        drain       <= start_pause && (phase_cnt == 6'd1);
                    end
                    SPIN: begin
                        phase_led   <= 3'b100;
                        remain_time <= remain_cnt;
                        drain       <= start_pause;
                        spin_motor  <= start_pause;
                    end
                    DONE:    buzzer <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - directed self-checking bench for wash_sequencer
module tb_wash_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sec_tick = 1'b0;
    logic       power_led = 1'b0;
    logic       start_pause = 1'b0;
    logic [2:0] model_now = 3'd0;
    logic       if_finish, wash_motor, water_in, drain, spin_motor, buzzer;
    logic [2:0] phase_led;
    logic [7:0] remain_time;

    int n_checks = 0;
    int n_fail   = 0;

    wash_sequencer dut (
        .clk(clk), .reset(reset), .sec_tick(sec_tick), .power_led(power_led),
        .start_pause(start_pause), .model_now(model_now), .if_finish(if_finish),
        .phase_led(phase_led), .wash_motor(wash_motor), .water_in(water_in),
        .drain(drain), .spin_motor(spin_motor), .buzzer(buzzer), .remain_time(remain_time)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
        step();
    endtask

    task automatic press(input logic [2:0] m);
        model_now   = m;
        start_pause = 1'b0;
        step();
        start_pause = 1'b1;
        step();
        step();
    endtask

    int wash_seen;

    initial begin
        step();
        check("reset_phase", phase_led, 3'b000);
        check("reset_remain", remain_time, 8'd0);
        check("reset_outs", {if_finish, wash_motor, water_in, drain, spin_motor, buzzer}, 6'd0);
        reset = 1'b1;
        power_led = 1'b1;
        step();

        // Mode 0 full programme
        press(3'd0);
        check("m0_remain_start", remain_time, 8'd18);
        check("m0_phase_wash", phase_led, 3'b001);
        check("m0_wash_fill", {wash_motor, water_in}, 2'b11);
        tick(); tick();
        check("m0_fill_end", {wash_motor, water_in}, 2'b10);
        for (int i = 2; i < 9; i++) tick();
        check("m0_phase_rinse", phase_led, 3'b010);
        check("m0_remain9", remain_time, 8'd9);
        check("m0_rinse_fill", {wash_motor, water_in, drain}, 3'b110);
        for (int i = 0; i < 5; i++) tick();
        check("m0_rinse_drain", {wash_motor, water_in, drain}, 3'b101);
        tick();
        check("m0_phase_spin", phase_led, 3'b100);
        check("m0_spin_outs", {drain, spin_motor, wash_motor}, 3'b110);
        tick(); tick();
        check("m0_remain1", remain_time, 8'd1);
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
        step();
        check("m0_finish", if_finish, 1'b1);
        check("m0_done_leds", {phase_led, remain_time}, 11'd0);
        check("m0_buzzer_on", buzzer, 1'b1);
        step();
        check("m0_finish_once", if_finish, 1'b0);
        tick();
        check("m0_buzzer_hold", buzzer, 1'b1);
        tick();
        check("m0_buzzer_off", buzzer, 1'b0);

        // Mode 5 spin only
        press(3'd5);
        check("m5_remain", remain_time, 8'd3);
        check("m5_outs", {phase_led, drain, spin_motor}, 5'b10011);
        wash_seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (wash_motor) wash_seen++;
            tick();
        end
        check("m5_finish", if_finish, 1'b1);
        check("m5_no_wash", wash_seen, 0);
        tick(); tick();

        // Mode 1 with pause
        press(3'd1);
        for (int i = 0; i < 4; i++) tick();
        start_pause = 1'b0;
        step();
        check("pause_remain", remain_time, 8'd5);
        check("pause_motors", {wash_motor, water_in, drain, spin_motor}, 4'd0);
        check("pause_led", phase_led, 3'b001);
        for (int i = 0; i < 5; i++) tick();
        check("pause_frozen", remain_time, 8'd5);
        start_pause = 1'b1;
        step();
        for (int i = 0; i < 4; i++) tick();
        check("pause_not_yet", {if_finish, remain_time}, 9'd1);
        tick();
        check("pause_finish", if_finish, 1'b1);
        tick(); tick();

        // Mode 2 power loss, then no restart while start_pause stays high
        press(3'd2);
        check("m2_remain", remain_time, 8'd15);
        for (int i = 0; i < 5; i++) tick();
        check("m2_remain10", remain_time, 8'd10);
        power_led = 1'b0;
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
        check("poff_outs", {if_finish, phase_led, wash_motor, water_in, drain, spin_motor, buzzer, remain_time}, 0);
        step();
        power_led = 1'b1;
        step(); step();
        check("poff_no_restart", {phase_led, remain_time}, 11'd0);
        check("poff_no_finish", if_finish, 1'b0);

        // Mode latch: start mode 3, change to 4 mid-run
        press(3'd3);
        check("m3_start", {phase_led, remain_time}, {3'b010, 8'd9});
        model_now = 3'd4;
        for (int i = 0; i < 6; i++) tick();
        check("m3_latched_spin", {phase_led, remain_time}, {3'b100, 8'd3});
        for (int i = 0; i < 5; i++) tick();

        // Mode 7 and async reset mid-wash
        press(3'd7);
        check("m7_remain", remain_time, 8'd18);
        tick();
        reset = 1'b0;
        #2;
        check("areset_outs", {phase_led, wash_motor, water_in, remain_time}, 0);
        reset = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
